if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the PC to the combinational instruction memory; receives the fetched word back in the same cycle.
- Latches the fetched word into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit stalls and branch/jump redirects from ID, and keeps fetch statistics counters.

---
 rtl/if_stage.sv | 140 ++++++++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, latches the fetched word into IF/ID,
// applies redirect/stall priority and keeps saturating fetch statistics.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    input  logic [31:0]      inst_in,
    output logic [31:0]      pc_out,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             misaligned_flag,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned     XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] NOP     = XLEN'(0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACT_NORMAL   = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_act_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    logic [XLEN-1:0]  r_pc;
    if_id_t           r_if_id;
    logic             r_misaligned;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    fetch_act_e       w_act;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_pc_nxt;
    if_id_t           w_if_id_nxt;
    logic             w_misaligned_nxt;
    logic             w_fetch_inc;
    logic             w_stall_inc;
    logic             w_flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign w_pc_plus4 = r_pc + PC_STEP;

    // Redirect outranks stall; stall outranks a normal fetch.
    always_comb begin
        w_act = ACT_NORMAL;
        if (redirect) begin
            w_act = ACT_REDIRECT;
        end else if (stall) begin
            w_act = ACT_STALL;
        end
    end

    always_comb begin
        w_pc_nxt         = r_pc;
        w_if_id_nxt      = r_if_id;
        w_misaligned_nxt = r_misaligned;
        w_fetch_inc      = 1'b0;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;
        case (w_act)
            ACT_NORMAL: begin
                w_pc_nxt          = w_pc_plus4;
                w_if_id_nxt.inst  = inst_in;
                w_if_id_nxt.pc4   = w_pc_plus4;
                w_if_id_nxt.valid = 1'b1;
                w_fetch_inc       = 1'b1;
            end
            ACT_STALL: begin
                w_stall_inc = 1'b1;
            end
            ACT_REDIRECT: begin
                // Target is word-aligned by dropping the low bits; the word fetched now is discarded.
                w_pc_nxt          = {redirect_target[XLEN-1:2], 2'b00};
                w_if_id_nxt.inst  = NOP;
                w_if_id_nxt.pc4   = NOP;
                w_if_id_nxt.valid = 1'b0;
                w_flush_inc       = 1'b1;
                if (redirect_target[1:0] != 2'b00) begin
                    w_misaligned_nxt = 1'b1;
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_if_id      <= '0;
            r_misaligned <= 1'b0;
            r_fetch_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_if_id      <= w_if_id_nxt;
            r_misaligned <= w_misaligned_nxt;
            if (w_fetch_inc) begin
                r_fetch_cnt <= sat_inc(r_fetch_cnt);
            end
            if (w_stall_inc) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_flush_inc) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign pc_out          = r_pc;
    assign if_id_inst      = r_if_id.inst;
    assign if_id_pc4       = r_if_id.pc4;
    assign if_id_valid     = r_if_id.valid;
    assign misaligned_flag = r_misaligned;
    assign fetch_count     = r_fetch_cnt;
    assign stall_count     = r_stall_cnt;
    assign flush_count     = r_flush_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Randomized check of if_stage against an abstract fetch model; a second
// instance with 4-bit counters exercises counter saturation.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        mem_is_pc;

    logic [31:0] inst_in,  pc_out,  if_id_inst,  if_id_pc4;
    logic        if_id_valid,  misaligned_flag;
    logic [31:0] fetch_count, stall_count, flush_count;

    logic [31:0] inst_in4, pc_out4, if_id_inst4, if_id_pc44;
    logic        if_id_valid4, misaligned_flag4;
    logic [3:0]  fetch_count4, stall_count4, flush_count4;

    int n_checks;
    int n_fail;

    // Reference state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_flag;
    longint      m_fetch, m_stall, m_flush;

    if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .inst_in(inst_in),
        .pc_out(pc_out), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .misaligned_flag(misaligned_flag),
        .fetch_count(fetch_count), .stall_count(stall_count), .flush_count(flush_count)
    );

    if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .inst_in(inst_in4),
        .pc_out(pc_out4), .if_id_inst(if_id_inst4), .if_id_pc4(if_id_pc44),
        .if_id_valid(if_id_valid4), .misaligned_flag(misaligned_flag4),
        .fetch_count(fetch_count4), .stall_count(stall_count4), .flush_count(flush_count4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic is_pc);
        return is_pc ? a : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
    endfunction

    always_comb inst_in  = mem_word(pc_out,  mem_is_pc);
    always_comb inst_in4 = mem_word(pc_out4, mem_is_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input longint maxv);
        return (v > maxv) ? 32'(maxv) : 32'(v);
    endfunction

    // One clock edge of the abstract fetch rules, with the word memory returns for the model PC.
    task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] t,
                              input logic [31:0] word);
        if (r) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_flag = 1'b0;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (rd) begin
            m_pc = t & ~32'h3;
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_flush++;
            if (t[1:0] != 2'b00) m_flag = 1'b1;
        end else if (s) begin
            m_stall++;
        end else begin
            m_inst = word;
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fetch++;
        end
    endtask

    task automatic check_all();
        check_eq("pc_out",      pc_out,                  m_pc);
        check_eq("if_id_inst",  if_id_inst,              m_inst);
        check_eq("if_id_pc4",   if_id_pc4,               m_pc4);
        check_eq("if_id_valid", {31'h0, if_id_valid},    {31'h0, m_valid});
        check_eq("misaligned",  {31'h0, misaligned_flag},{31'h0, m_flag});
        check_eq("fetch_count", fetch_count,             sat(m_fetch, 64'hFFFF_FFFF));
        check_eq("stall_count", stall_count,             sat(m_stall, 64'hFFFF_FFFF));
        check_eq("flush_count", flush_count,             sat(m_flush, 64'hFFFF_FFFF));
        check_eq("pc_out4",     pc_out4,                 m_pc);
        check_eq("fetch_cnt4",  {28'h0, fetch_count4},   sat(m_fetch, 15));
        check_eq("stall_cnt4",  {28'h0, stall_count4},   sat(m_stall, 15));
        check_eq("flush_cnt4",  {28'h0, flush_count4},   sat(m_flush, 15));
    endtask

    // Apply inputs, take one edge, advance the model, then check after the edge.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t);
        logic [31:0] word;
        rst = r; stall = s; redirect = rd; redirect_target = t;
        word = mem_word(m_pc, mem_is_pc);
        @(posedge clk);
        model_edge(r, s, rd, t, word);
        #1;
        check_all();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; mem_is_pc = 1'b1;
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_flag = 1'b0;
        m_fetch = 0; m_stall = 0; m_flush = 0;
        #2;

        // Free-running fetch from reset
        step(1, 0, 0, 0);
        check_eq("rst_pc", pc_out, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check_eq("run_inst", if_id_inst, 32'd12);
        check_eq("run_pc4", if_id_pc4, 32'd16);
        check_eq("run_fetch", fetch_count, 32'd4);

        // Stall holds PC and IF/ID
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check_eq("stall_pc", pc_out, 32'd8);
        check_eq("stall_inst", if_id_inst, 32'd4);
        check_eq("stall_cnt", stall_count, 32'd3);
        check_eq("stall_fetch", fetch_count, 32'd2);
        step(0, 0, 0, 0);
        check_eq("stall_rel_pc", pc_out, 32'd12);

        // Redirect wins over stall
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        check_eq("pre_redir_pc", pc_out, 32'd20);
        step(0, 1, 1, 32'h40);
        check_eq("redir_pc", pc_out, 32'h40);
        check_eq("redir_valid", {31'h0, if_id_valid}, 32'h0);
        check_eq("redir_flush", flush_count, 32'd1);
        check_eq("redir_stall", stall_count, 32'd0);
        step(0, 0, 0, 0);
        check_eq("post_redir_inst", if_id_inst, 32'h40);

        // Misaligned target: sticky flag until reset
        step(0, 0, 1, 32'h46);
        check_eq("mis_pc", pc_out, 32'h44);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check_eq("mis_sticky", {31'h0, misaligned_flag}, 32'h1);
        step(1, 0, 0, 0);
        check_eq("mis_clear", {31'h0, misaligned_flag}, 32'h0);

        // PC wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        check_eq("wrap_pc0", pc_out, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check_eq("wrap_pc1", pc_out, 32'h0);
        check_eq("wrap_pc4", if_id_pc4, 32'h0);
        step(0, 0, 0, 0);
        check_eq("wrap_pc2", pc_out, 32'h4);

        // Saturation of the narrow counters, then reset dominating stall+redirect
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check_eq("sat_fetch4", {28'h0, fetch_count4}, 32'd15);
        step(1, 1, 1, 32'h80);
        check_eq("rst_dom_pc", pc_out, 32'h0);
        check_eq("rst_dom_fetch4", {28'h0, fetch_count4}, 32'd0);

        // Random traffic with a hashed memory image
        mem_is_pc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic r, s, rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 5) == 0);
            t  = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            step(r, s, rd, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
